// File: rtl/ysyx_22040127_lsu_ctrl_pkg.sv
// Shared LSU definitions: FSM state encoding, access-size codes and size helper.
// REQ2/WAIT2 are only reachable when YSYX_22040127_LSU_MISALIGN_SPLIT_EN is defined.
package ysyx_22040127_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    REQ2  = 3'd4,
    WAIT2 = 3'd5
  } lsu_state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/ysyx_22040127_lsu_extend.sv
// Combinational load-data extractor: shifts the addressed bytes down to bit 0,
// then sign- or zero-extends them according to the access size.
module ysyx_22040127_lsu_extend
  import ysyx_22040127_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0]            data,
  input  logic [$clog2(DATA_W/8)-1:0]  off,
  input  logic [1:0]                   size,
  input  logic                         is_unsigned,
  output logic [DATA_W-1:0]            ext
);

  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] keep;
  logic              msb;
  logic              sign;

  assign shifted = data >> {off, 3'b000};

  // keep marks the bits belonging to the access; everything above is fill
  always_comb begin
    keep = '1;
    msb  = shifted[DATA_W-1];
    unique case (size)
      SZ_B: begin
        keep = DATA_W'(8'hFF);
        msb  = shifted[7];
      end
      SZ_H: begin
        keep = DATA_W'(16'hFFFF);
        msb  = shifted[15];
      end
      SZ_W: begin
        keep = DATA_W'(32'hFFFF_FFFF);
        msb  = shifted[31];
      end
      default: begin
        keep = '1;
        msb  = shifted[DATA_W-1];
      end
    endcase
    sign = msb & ~is_unsigned;
    ext  = (shifted & keep) | (~keep & {DATA_W{sign}});
  end

endmodule

// File: rtl/ysyx_22040127_lsu_ctrl.sv
// Load/store unit: EXU handshake in, aligned word bus out, extended load data back.
// Define YSYX_22040127_LSU_MISALIGN_SPLIT_EN to split word-crossing accesses into two beats.
module ysyx_22040127_lsu_ctrl
  import ysyx_22040127_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err,
  output logic                  mem_req,
  input  logic                  mem_gnt,
  output logic                  mem_wen,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wmask,
  input  logic                  mem_rvalid,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  lsu_state_t state, next_state, first_done;

  logic              wen_q, uns_q, err_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic [OFF_W-1:0]  off_q;

  logic misalign, illegal, req_err, req_split;
  logic hi_beat;

  logic [2*NB-1:0]     mask_base, mask_wide;
  logic [2*DATA_W-1:0] wdata_wide;
  logic [ADDR_W-1:0]   addr_lo, addr_hi;

  logic [DATA_W-1:0]   ext_in, ext_data;
  logic [OFF_W-1:0]    ext_off;

  assign off_q = addr_q[OFF_W-1:0];

  always_comb begin
    misalign = 1'b0;
    unique case (req_size)
      SZ_B:    misalign = 1'b0;
      SZ_H:    misalign = req_addr[0];
      SZ_W:    misalign = |req_addr[1:0];
      default: misalign = |req_addr[2:0];
    endcase
  end

  assign illegal = (DATA_W == 32) && (req_size == SZ_D);

`ifdef YSYX_22040127_LSU_MISALIGN_SPLIT_EN
  logic [4:0]        cross_sum;
  logic              split_q;
  logic [DATA_W-1:0] lo_q;
  logic [DATA_W-1:0] merged;

  assign cross_sum = 5'(req_addr[OFF_W-1:0]) + 5'(size_bytes(req_size));
  assign req_split = misalign && (cross_sum > 5'(NB));
  assign req_err   = illegal;
  assign hi_beat   = (state == REQ2);

  // Split loads: the low word sits in lo_q while the high word arrives on the bus
  assign merged  = DATA_W'({mem_rdata, lo_q} >> {off_q, 3'b000});
  assign ext_in  = split_q ? merged : mem_rdata;
  assign ext_off = split_q ? '0 : off_q;
`else
  assign req_split = 1'b0;
  assign req_err   = misalign | illegal;
  assign hi_beat   = 1'b0;
  assign ext_in    = mem_rdata;
  assign ext_off   = off_q;
`endif

  always_comb begin
    mask_base = '0;
    unique case (size_q)
      SZ_B:    mask_base = (2*NB)'(8'h01);
      SZ_H:    mask_base = (2*NB)'(8'h03);
      SZ_W:    mask_base = (2*NB)'(8'h0F);
      default: mask_base = (2*NB)'(8'hFF);
    endcase
    mask_wide  = mask_base << off_q;
    wdata_wide = {{DATA_W{1'b0}}, wdata_q} << {off_q, 3'b000};
  end

  assign addr_lo = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign addr_hi = addr_lo + ADDR_W'(NB);

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_err   = resp_valid & err_q;
  assign resp_rdata = rdata_q;

  assign mem_req   = (state == REQ) | hi_beat;
  assign mem_wen   = mem_req & wen_q;
  assign mem_addr  = mem_req ? (hi_beat ? addr_hi : addr_lo) : '0;
  assign mem_wmask = mem_wen ? (hi_beat ? mask_wide[2*NB-1:NB] : mask_wide[NB-1:0]) : '0;
  assign mem_wdata = mem_wen ? (hi_beat ? wdata_wide[2*DATA_W-1:DATA_W]
                                        : wdata_wide[DATA_W-1:0]) : '0;

  ysyx_22040127_lsu_extend #(
    .DATA_W (DATA_W)
  ) u_extend (
    .data        (ext_in),
    .off         (ext_off),
    .size        (size_q),
    .is_unsigned (uns_q),
    .ext         (ext_data)
  );

  always_comb begin
    next_state = state;
`ifdef YSYX_22040127_LSU_MISALIGN_SPLIT_EN
    first_done = split_q ? REQ2 : RESP;
`else
    first_done = RESP;
`endif
    unique case (state)
      IDLE:  if (req_valid) next_state = req_err ? RESP : REQ;
      REQ:   if (mem_gnt) next_state = mem_rvalid ? first_done : WAIT;
      WAIT:  if (mem_rvalid) next_state = first_done;
`ifdef YSYX_22040127_LSU_MISALIGN_SPLIT_EN
      REQ2:  if (mem_gnt) next_state = mem_rvalid ? RESP : WAIT2;
      WAIT2: if (mem_rvalid) next_state = RESP;
`endif
      RESP:  if (resp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wen_q   <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= SZ_B;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state == IDLE && req_valid) begin
      wen_q   <= req_wen;
      uns_q   <= req_unsigned;
      err_q   <= req_err;
      size_q  <= req_size;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Response data is written once, on the transition into RESP; errors and stores return 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (next_state == RESP && state != RESP) begin
      rdata_q <= (state == IDLE || wen_q) ? '0 : ext_data;
    end
  end

`ifdef YSYX_22040127_LSU_MISALIGN_SPLIT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      split_q <= 1'b0;
      lo_q    <= '0;
    end else begin
      if (state == IDLE && req_valid) split_q <= req_split;
      if (split_q && mem_rvalid && ((state == REQ && mem_gnt) || state == WAIT))
        lo_q <= mem_rdata;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_22040127_lsu_ctrl.sv
// Scoreboard bench for ysyx_22040127_lsu_ctrl (DATA_W=64): expected memory beats and
// responses are queued by the stimulus and popped by monitors on the falling edge.
module tb_ysyx_22040127_lsu_ctrl;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wen, req_unsigned;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [63:0] resp_rdata;
  logic        mem_req, mem_gnt, mem_wen, mem_rvalid;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } resp_t;

  typedef struct {
    logic        wen;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
  } beat_t;

  resp_t resp_q[$];
  beat_t mem_q[$];
  int errors = 0;
  int checks = 0;

  ysyx_22040127_lsu_ctrl #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_wen      (req_wen),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_req      (mem_req),
    .mem_gnt      (mem_gnt),
    .mem_wen      (mem_wen),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wmask    (mem_wmask),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, actual, expected);
    end
  endtask

  task automatic expectBeat(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                            input logic [7:0] wmask);
    beat_t b;
    b.wen = wen; b.addr = addr; b.wdata = wdata; b.wmask = wmask;
    mem_q.push_back(b);
  endtask

  task automatic expectResp(input logic [63:0] rdata, input logic err);
    resp_t r;
    r.rdata = rdata; r.err = err;
    resp_q.push_back(r);
  endtask

  // Memory-side monitor: every cycle mem_req is up, the bus must match the queued beat
  always @(negedge clk) begin
    if (!rst && mem_req) begin
      if (mem_q.size() == 0) begin
        checkOutput("unexpected mem_req", mem_req, 1'b0);
      end else begin
        checkOutput("mem_wen", mem_wen, mem_q[0].wen);
        checkOutput("mem_addr", mem_addr, mem_q[0].addr);
        checkOutput("mem_wdata", mem_wdata, mem_q[0].wdata);
        checkOutput("mem_wmask", mem_wmask, mem_q[0].wmask);
        if (mem_gnt) void'(mem_q.pop_front());
      end
    end
  end

  // Response monitor: data and error must hold while resp_valid waits for resp_ready
  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      checkOutput("req_ready during resp", req_ready, 1'b0);
      if (resp_q.size() == 0) begin
        checkOutput("unexpected resp_valid", resp_valid, 1'b0);
      end else begin
        checkOutput("resp_rdata", resp_rdata, resp_q[0].rdata);
        checkOutput("resp_err", resp_err, resp_q[0].err);
        if (resp_ready) void'(resp_q.pop_front());
      end
    end
  end

  task automatic applyStimulus(input logic wen, input logic [1:0] size, input logic uns,
                               input logic [63:0] addr, input logic [63:0] wdata,
                               input int nbeats, input int gnt_dly, input int rv_dly,
                               input logic [63:0] rd0, input logic [63:0] rd1, input int rdy_dly);
    int n;
    @(posedge clk); #1;
    req_valid = 1'b1; req_wen = wen; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 50);
    @(posedge clk); #1;
    req_valid = 1'b0;

    for (int b = 0; b < nbeats; b++) begin
      n = 0;
      while (!mem_req && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (!mem_req) begin
        checkOutput("mem_req timeout", mem_req, 1'b1);
        return;
      end
      repeat (gnt_dly) @(posedge clk);
      @(posedge clk); #1;
      mem_gnt = 1'b1;
      if (rv_dly == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = (b == 0) ? rd0 : rd1;
      end
      @(posedge clk); #1;
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      if (rv_dly > 0) begin
        repeat (rv_dly - 1) begin
          @(posedge clk); #1;
        end
        mem_rvalid = 1'b1;
        mem_rdata  = (b == 0) ? rd0 : rd1;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
      end
    end

    n = 0;
    while (!resp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!resp_valid) begin
      checkOutput("resp_valid timeout", resp_valid, 1'b1);
      return;
    end
    repeat (rdy_dly) @(posedge clk);
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    @(negedge clk);
    checkOutput("req_ready after handshake", req_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_wen = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset req_ready", req_ready, 1'b1);
    checkOutput("reset resp_valid", resp_valid, 1'b0);
    checkOutput("reset resp_err", resp_err, 1'b0);
    checkOutput("reset resp_rdata", resp_rdata, 64'h0);
    checkOutput("reset mem_req", mem_req, 1'b0);
    checkOutput("reset mem_wmask", mem_wmask, 8'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    $display("[TB] signed / unsigned byte loads");
    expectBeat(1'b0, 64'h8000_0000, 64'h0, 8'h00);
    expectResp(64'hFFFF_FFFF_FFFF_FF80, 1'b0);
    applyStimulus(1'b0, 2'd0, 1'b0, 64'h8000_0003, 64'h0, 1, 0, 1, 64'h0000_0000_8000_0000, 64'h0, 0);
    expectBeat(1'b0, 64'h8000_0000, 64'h0, 8'h00);
    expectResp(64'h0000_0000_0000_0080, 1'b0);
    applyStimulus(1'b0, 2'd0, 1'b1, 64'h8000_0003, 64'h0, 1, 0, 1, 64'h0000_0000_8000_0000, 64'h0, 0);

    $display("[TB] half store lane placement");
    expectBeat(1'b1, 64'h8000_0000, 64'h1234_0000_0000_0000, 8'hC0);
    expectResp(64'h0, 1'b0);
    applyStimulus(1'b1, 2'd1, 1'b0, 64'h8000_0006, 64'h1234, 1, 0, 1, 64'h0, 64'h0, 0);

    $display("[TB] slow grant, slow rvalid, stalled WBU");
    expectBeat(1'b0, 64'h8000_0010, 64'h0, 8'h00);
    expectResp(64'hDEAD_BEEF_0123_4567, 1'b0);
    applyStimulus(1'b0, 2'd3, 1'b0, 64'h8000_0010, 64'h0, 1, 2, 5, 64'hDEAD_BEEF_0123_4567, 64'h0, 3);

    $display("[TB] grant and rvalid together, word and half loads");
    expectBeat(1'b0, 64'h8000_0000, 64'h0, 8'h00);
    expectResp(64'hFFFF_FFFF_8765_4321, 1'b0);
    applyStimulus(1'b0, 2'd2, 1'b0, 64'h8000_0004, 64'h0, 1, 0, 0, 64'h8765_4321_0000_0000, 64'h0, 1);
    expectBeat(1'b0, 64'h8000_0008, 64'h0, 8'h00);
    expectResp(64'hFFFF_FFFF_FFFF_BEEF, 1'b0);
    applyStimulus(1'b0, 2'd1, 1'b0, 64'h8000_000A, 64'h0, 1, 1, 2, 64'h0000_0000_BEEF_0000, 64'h0, 0);

    $display("[TB] word and double stores");
    expectBeat(1'b1, 64'h8000_0000, 64'hCAFE_BABE_0000_0000, 8'hF0);
    expectResp(64'h0, 1'b0);
    applyStimulus(1'b1, 2'd2, 1'b0, 64'h8000_0004, 64'hCAFE_BABE, 1, 0, 1, 64'h0, 64'h0, 0);
    expectBeat(1'b1, 64'h8000_0008, 64'h1122_3344_5566_7788, 8'hFF);
    expectResp(64'h0, 1'b0);
    applyStimulus(1'b1, 2'd3, 1'b0, 64'h8000_0008, 64'h1122_3344_5566_7788, 1, 0, 1, 64'h0, 64'h0, 0);

    $display("[TB] misaligned accesses");
`ifdef YSYX_22040127_LSU_MISALIGN_SPLIT_EN
    expectBeat(1'b0, 64'h8000_0000, 64'h0, 8'h00);
    expectResp(64'h0000_0000_1234_5678, 1'b0);
    applyStimulus(1'b0, 2'd2, 1'b0, 64'h8000_0002, 64'h0, 1, 0, 1, 64'h0000_1234_5678_0000, 64'h0, 0);
    expectBeat(1'b0, 64'h8000_0000, 64'h0, 8'h00);
    expectResp(64'hFFFF_FFFF_FFFF_ABCD, 1'b0);
    applyStimulus(1'b0, 2'd1, 1'b0, 64'h8000_0001, 64'h0, 1, 0, 1, 64'h0000_0000_00AB_CD00, 64'h0, 0);
    expectBeat(1'b1, 64'h8000_0000, 64'hCCDD_0000_0000_0000, 8'hC0);
    expectBeat(1'b1, 64'h8000_0008, 64'h0000_0000_0000_AABB, 8'h03);
    expectResp(64'h0, 1'b0);
    applyStimulus(1'b1, 2'd2, 1'b0, 64'h8000_0006, 64'hAABB_CCDD, 2, 0, 1, 64'h0, 64'h0, 0);
    expectBeat(1'b0, 64'h8000_0000, 64'h0, 8'h00);
    expectBeat(1'b0, 64'h8000_0008, 64'h0, 8'h00);
    expectResp(64'hFFFF_FFFF_8899_1122, 1'b0);
    applyStimulus(1'b0, 2'd2, 1'b0, 64'h8000_0006, 64'h0, 2, 1, 2,
                  64'h1122_0000_0000_0000, 64'h0000_0000_0000_8899, 1);
`else
    expectResp(64'h0, 1'b1);
    applyStimulus(1'b0, 2'd2, 1'b0, 64'h8000_0002, 64'h0, 0, 0, 0, 64'h0, 64'h0, 0);
    expectResp(64'h0, 1'b1);
    applyStimulus(1'b0, 2'd1, 1'b0, 64'h8000_0001, 64'h0, 0, 0, 0, 64'h0, 64'h0, 1);
    expectResp(64'h0, 1'b1);
    applyStimulus(1'b1, 2'd2, 1'b0, 64'h8000_0006, 64'hAABB_CCDD, 0, 0, 0, 64'h0, 64'h0, 0);
    expectResp(64'h0, 1'b1);
    applyStimulus(1'b0, 2'd3, 1'b0, 64'h8000_0004, 64'h0, 0, 0, 0, 64'h0, 64'h0, 2);
`endif

    $display("[TB] reset while waiting for memory");
    expectBeat(1'b0, 64'h8000_0020, 64'h0, 8'h00);
    @(posedge clk); #1;
    req_valid = 1'b1; req_wen = 1'b0; req_size = 2'd3; req_unsigned = 1'b0;
    req_addr = 64'h8000_0020; req_wdata = '0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    rst = 1'b1;
    #2;
    checkOutput("rst in WAIT req_ready", req_ready, 1'b1);
    checkOutput("rst in WAIT mem_req", mem_req, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    mem_rvalid = 1'b1;
    mem_rdata  = 64'h5555_AAAA_5555_AAAA;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("late rvalid resp_valid", resp_valid, 1'b0);
      checkOutput("late rvalid req_ready", req_ready, 1'b1);
    end

    repeat (3) @(posedge clk);
    checkOutput("resp queue drained", 64'(resp_q.size()), 64'h0);
    checkOutput("mem queue drained", 64'(mem_q.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ysyx_22040127_lsu_ctrl.md
Name: ysyx_22040127_lsu_ctrl

Overview:
Parametrised load/store unit that replaces the combinational DPI memory access path. It accepts one load or store per valid/ready handshake from EXU and drives an aligned word bus to the memory/AXI side. It waits a variable number of cycles for the response, then returns sign- or zero-extended load data to WBU. It also flags misaligned accesses.

Parameters:
DATA_W, 64, memory data bus width; must be 32 or 64.
ADDR_W, 64, address width.
NB, DATA_W/8, byte lanes (derived; localparam).
OFF_W, $clog2(NB), byte-offset bits (derived; localparam).

Ports:
clk  in  1  system clock, all flops rising edge
rst  in  1  asynchronous active-high reset
req_valid  in  1  EXU request valid
req_ready  out  1  LSU can accept a request
req_wen  in  1  1 = store, 0 = load
req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double (3 is illegal when DATA_W=32)
req_unsigned  in  1  zero-extend the load (lbu/lhu/lwu)
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  store data, right-aligned
resp_valid  out  1  response valid to WBU
resp_ready  in  1  WBU accepts the response
resp_rdata  out  DATA_W  extended load data; 0 for stores
resp_err  out  1  misaligned or illegal-size access
mem_req  out  1  memory request strobe
mem_gnt  in  1  memory accepted the request
mem_wen  out  1  write request
mem_addr  out  ADDR_W  req_addr with the low OFF_W bits cleared
mem_wdata  out  DATA_W  store data shifted to its byte lane
mem_wmask  out  NB  byte enables (all 0 for reads)
mem_rvalid  in  1  read data / write ack valid
mem_rdata  in  DATA_W  aligned read word

Behaviour:
- FSM states: IDLE, REQ, WAIT, RESP. Reset state is IDLE.
- Reset values: all outputs 0, except req_ready = 1.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch wen, size, unsigned, addr, wdata.
  - Error check: misalign = addr[size-1:0] != 0 (never for byte); size 3 with DATA_W=32 is also an error.
  - On error, go to RESP with resp_err = 1 (behaviour depends on the optional feature). Otherwise go to REQ.
- REQ:
  - mem_req = 1, holding address, data and mask stable until mem_gnt.
  - On mem_gnt, go to WAIT. If mem_gnt and mem_rvalid are high in the same cycle, go straight to RESP.
- WAIT: on mem_rvalid, capture mem_rdata and go to RESP. No timeout.
- RESP:
  - resp_valid held until resp_ready, then go to IDLE. No back-to-back bypass: throughput is at most 1 access per 3 cycles.
- Write lanes: mem_wmask = ((1 << (1 << size)) - 1) << addr[OFF_W-1:0]; mem_wdata = wdata << (8 * offset).
- Load extract: shifted = mem_rdata >> (8 * offset), truncated to 8 << size bits.
  - Sign-extend from the top bit when unsigned = 0, otherwise zero-extend.
  - A size-3 load is a pass-through.
- resp_rdata is registered; it changes only on entry to RESP.
- An asynchronous rst in any state returns to IDLE immediately and drops mem_req and resp_valid. An in-flight memory response arriving after reset is ignored.

Optional Feature:
Macro: YSYX_22040127_LSU_MISALIGN_SPLIT_EN.
- With the macro defined:
  - A misaligned access that crosses the DATA_W boundary is split into two aligned beats.
  - Added states: REQ2, WAIT2.
  - The low part is merged into a holding register, then the high part. resp_err is asserted only for illegal size.
  - A misaligned access inside one word needs no split; shift and mask handle it in one beat.
- Without the macro: any misaligned access issues no mem_req and responds in RESP with resp_err = 1 and resp_rdata = 0.

Decomposition:
- Shared package (ysyx_22040127_pkg) holds:
  - state encoding enum lsu_state_t;
  - size constants SZ_B = 0, SZ_H = 1, SZ_W = 2, SZ_D = 3;
  - function size_bytes(size).
- One natural sub-module: ysyx_22040127_lsu_extend, a combinational shift plus sign/zero-extend keyed by offset, size and unsigned. It replaces the hand-written lane OR-trees and is reused by a future cache.

Test Plan:
- Load byte signed, DATA_W=64: addr 0x8000_0003, mem_rdata 0x0000_0000_8000_0000 → offset 3 selects 0x80, resp_rdata 0xFFFF_FFFF_FFFF_FF80, resp_err 0.
- Same access with unsigned = 1 → resp_rdata 0x0000_0000_0000_0080.
- Store half: addr 0x8000_0006, wdata 0x1234 → mem_wmask 0xC0, mem_wdata[63:48] = 0x1234, mem_addr 0x8000_0000.
- Memory latency: mem_gnt arrives after 2 cycles, mem_rvalid 5 cycles later, resp_ready held low for 3 cycles → resp_valid and resp_rdata stable throughout; req_ready stays 0 until the cycle after the handshake.
- Misaligned lw at 0x8000_0002:
  - Feature off → no mem_req, resp_err 1.
  - Feature on, at 0x8000_0006 → two beats with masks 0xC0 then 0x03, and the merged word returned.
- Assert rst while in WAIT, then raise mem_rvalid one cycle later → FSM is in IDLE, resp_valid stays 0, req_ready is 1.
